// File: rtl/imem_fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, fetches one word per cycle from a
// combinational instruction memory, queues {pc, instr} and hands them to decode
// over valid/ready. Supports start, branch redirect with flush, and halt on a
// sentinel instruction word.
module imem_fetch_sequencer #(
  parameter int                ADDR_W    = 10,
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 2,
  parameter logic [DATA_W-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_pc,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic              halted,
  output logic [15:0]       fetch_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HALTED} state_t;

  state_t                         state, state_nxt;
  logic [ADDR_W-1:0]              fetch_pc, fetch_pc_nxt;
  logic [DEPTH-1:0][DATA_W-1:0]   instr_q;
  logic [DEPTH-1:0][ADDR_W-1:0]   pc_q;
  logic [PTR_W-1:0]               rd_ptr, wr_ptr, rd_nxt;
  logic [CNT_W-1:0]               count, cnt_nxt;
  logic                           redirect, full, pop, push;
  logic [DATA_W-1:0]              head_instr;
  logic [ADDR_W-1:0]              head_pc;

  assign imem_addr = fetch_pc;
  assign out_valid = (count != '0);
  assign halted    = (state == S_HALTED);

  // Redirect wins over everything; a pop in a redirect cycle is discarded.
  assign redirect = redirect_valid && (state != S_IDLE);
  assign full     = (count == CNT_W'(DEPTH));
  assign pop      = out_valid && out_ready && !redirect;
  assign push     = (state == S_FETCH) && !redirect && (!full || pop);

  // Next-state and next fetch address.
  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt    = S_FETCH;
          fetch_pc_nxt = start_pc;
        end
      end
      S_FETCH, S_HALTED: begin
        if (redirect) begin
          state_nxt    = S_FETCH;
          fetch_pc_nxt = redirect_pc;
        end else if (push) begin
          fetch_pc_nxt = fetch_pc + ADDR_W'(1);
          if (imem_data == HALT_WORD) state_nxt = S_HALTED;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State and PC registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      fetch_pc <= '0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
    end
  end

  // Next head of queue: a word pushed into an (effectively) empty queue is
  // bypassed straight into the head registers so latency stays one cycle.
  always_comb begin
    rd_nxt  = rd_ptr + PTR_W'(pop);
    cnt_nxt = redirect ? '0 : (count + CNT_W'(push) - CNT_W'(pop));
    if (push && (wr_ptr == rd_nxt)) begin
      head_instr = imem_data;
      head_pc    = fetch_pc;
    end else begin
      head_instr = instr_q[rd_nxt];
      head_pc    = pc_q[rd_nxt];
    end
  end

  // Queue storage and pointers; redirect flushes by resetting pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= '0;
      pc_q    <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
    end else if (redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        instr_q[wr_ptr] <= imem_data;
        pc_q[wr_ptr]    <= fetch_pc;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_nxt;
      count <= cnt_nxt;
    end
  end

  // Registered head outputs; they hold their last value while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_instr <= '0;
      out_pc    <= '0;
    end else if (cnt_nxt != '0) begin
      out_instr <= head_instr;
      out_pc    <= head_pc;
    end
  end

  // Saturating push counter, survives redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fetch_count <= '0;
    else if (push && (fetch_count != 16'hFFFF)) fetch_count <= fetch_count + 16'd1;
  end

endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// Bench for imem_fetch_sequencer: directed scenarios from the test plan plus a
// randomized run checked against a queue-based reference model.
module tb_imem_fetch_sequencer;

  localparam int AW  = 10;
  localparam int DW  = 32;
  localparam int DEP = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] start_pc = '0;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_data;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_instr;
  logic [AW-1:0] out_pc;
  logic          halted;
  logic [15:0]   fetch_count;

  int halt_addr = 6;
  int n_chk = 0;
  int n_fail = 0;

  imem_fetch_sequencer #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP), .HALT_WORD(32'hFFFF_FFFF)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_pc(start_pc),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .halted(halted), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // Instruction memory model: word(a) = a + 100, except the halt address.
  assign imem_data = (int'(imem_addr) == halt_addr) ? 32'hFFFF_FFFF : ({22'd0, imem_addr} + 32'd100);

  // Reference model: 0 idle, 1 fetching, 2 halted; queue of {pc, instr}.
  typedef struct {
    logic [AW-1:0] pc;
    logic [DW-1:0] instr;
  } ent_t;

  int            m_state;
  logic [AW-1:0] m_pc;
  ent_t          mq[$];
  logic [AW-1:0] m_hpc;
  logic [DW-1:0] m_hin;
  int            m_cnt;
  int            seen[$];

  task automatic model_reset();
    m_state = 0; m_pc = '0; mq.delete(); m_hpc = '0; m_hin = '0; m_cnt = 0;
  endtask

  // One clock: log DUT handshakes, advance the model, advance the clock.
  task automatic tick();
    bit redir, pop, push;
    ent_t e;
    if (out_valid && out_ready && !redirect_valid) seen.push_back(int'(out_pc));
    redir = redirect_valid && (m_state != 0);
    pop   = (mq.size() > 0) && out_ready && !redir;
    push  = (m_state == 1) && !redir && ((mq.size() < DEP) || pop);
    if (redir) begin
      mq.delete();
      m_pc = redirect_pc;
      m_state = 1;
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) begin
        e.pc = m_pc;
        e.instr = (int'(m_pc) == halt_addr) ? 32'hFFFF_FFFF : ({22'd0, m_pc} + 32'd100);
        mq.push_back(e);
        if (m_cnt < 65535) m_cnt++;
        if (e.instr == 32'hFFFF_FFFF) m_state = 2;
        m_pc = m_pc + 10'd1;
      end
      if (m_state == 0 && start) begin
        m_state = 1;
        m_pc = start_pc;
      end
    end
    if (mq.size() > 0) begin
      m_hpc = mq[0].pc;
      m_hin = mq[0].instr;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; redirect_valid = 1'b0; out_ready = 1'b0;
    model_reset();
    seen.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++;
    if ({out_valid, out_pc, out_instr, halted, fetch_count, imem_addr} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got valid=%0b pc=%0d instr=%h halted=%0b cnt=%0d addr=%0d, want all 0",
               out_valid, out_pc, out_instr, halted, fetch_count, imem_addr);
    end
  endtask

  task automatic test_sequential();
    bit ok;
    do_reset();
    halt_addr = 6; out_ready = 1'b1; start = 1'b1; start_pc = '0;
    tick();
    start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      n_chk++;
      ok = (k >= 1 && k <= 7) ? (out_valid === 1'b1 && out_pc === 10'(k - 1) &&
             out_instr === ((k == 7) ? 32'hFFFF_FFFF : 32'(100 + k - 1)))
           : (out_valid === 1'b0);
      if (!ok) begin
        n_fail++;
        $display("FAIL seq_cycle%0d: got valid=%0b pc=%0d instr=%h", k, out_valid, out_pc, out_instr);
      end
      tick();
    end
    n_chk++;
    ok = (seen.size() == 7);
    foreach (seen[i]) if (seen[i] != i) ok = 1'b0;
    if (!ok) begin n_fail++; $display("FAIL seq_order: got %0d words delivered, want 0..6", seen.size()); end
    n_chk++;
    if (halted !== 1'b1 || fetch_count !== 16'd7 || imem_addr !== 10'd7) begin
      n_fail++;
      $display("FAIL seq_end: got halted=%0b cnt=%0d addr=%0d, want 1 7 7", halted, fetch_count, imem_addr);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    do_reset();
    halt_addr = 6; out_ready = 1'b0; start = 1'b1; start_pc = '0;
    tick();
    start = 1'b0;
    repeat (5) tick();
    n_chk++;
    if (imem_addr !== 10'd2 || out_valid !== 1'b1 || out_pc !== 10'd0 || fetch_count !== 16'd2) begin
      n_fail++;
      $display("FAIL bp_full: got addr=%0d valid=%0b pc=%0d cnt=%0d, want 2 1 0 2",
               imem_addr, out_valid, out_pc, fetch_count);
    end
    out_ready = 1'b1;
    repeat (4) tick();
    n_chk++;
    ok = (seen.size() == 4);
    foreach (seen[i]) if (seen[i] != i) ok = 1'b0;
    if (!ok) begin n_fail++; $display("FAIL bp_order: got %0d words, want 0,1,2,3", seen.size()); end
  endtask

  task automatic test_redirect();
    bit ok;
    do_reset();
    halt_addr = 6; out_ready = 1'b1; start = 1'b1; start_pc = '0;
    tick();
    start = 1'b0;
    repeat (4) tick();
    out_ready = 1'b0;
    tick();
    n_chk++;
    if (out_pc !== 10'd3 || imem_addr !== 10'd5 || fetch_count !== 16'd5) begin
      n_fail++;
      $display("FAIL redir_setup: got pc=%0d addr=%0d cnt=%0d, want 3 5 5", out_pc, imem_addr, fetch_count);
    end
    redirect_valid = 1'b1; redirect_pc = 10'd20; out_ready = 1'b1;
    tick();
    redirect_valid = 1'b0;
    n_chk++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL redir_flush: got valid=%0b, want 0", out_valid); end
    tick();
    n_chk++;
    if (out_valid !== 1'b1 || out_pc !== 10'd20 || out_instr !== 32'd120) begin
      n_fail++;
      $display("FAIL redir_target: got valid=%0b pc=%0d instr=%0d, want 1 20 120", out_valid, out_pc, out_instr);
    end
    repeat (4) tick();
    n_chk++;
    ok = (seen.size() >= 4) && seen[0] == 0 && seen[1] == 1 && seen[2] == 2 && seen[3] == 20;
    foreach (seen[i]) if (seen[i] == 3 || seen[i] == 4) ok = 1'b0;
    if (!ok) begin n_fail++; $display("FAIL redir_order: got %0d words, want 0,1,2,20,... without 3/4", seen.size()); end
  endtask

  task automatic test_wrap();
    bit ok;
    int exp[5] = '{1022, 1023, 0, 1, 2};
    do_reset();
    halt_addr = 2; out_ready = 1'b1; start = 1'b1; start_pc = 10'd1022;
    tick();
    start = 1'b0;
    repeat (10) tick();
    n_chk++;
    ok = (seen.size() == 5);
    foreach (seen[i]) if (i < 5 && seen[i] != exp[i]) ok = 1'b0;
    if (!ok) begin n_fail++; $display("FAIL wrap_order: got %0d words, want 1022,1023,0,1,2", seen.size()); end
    n_chk++;
    if (halted !== 1'b1 || imem_addr !== 10'd3) begin
      n_fail++;
      $display("FAIL wrap_halt: got halted=%0b addr=%0d, want 1 3", halted, imem_addr);
    end
  endtask

  // Runs from the halted state left by test_wrap.
  task automatic test_halt_redirect_reset();
    redirect_valid = 1'b1; redirect_pc = 10'd10;
    tick();
    redirect_valid = 1'b0;
    n_chk++;
    if (halted !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_redir: got halted=%0b valid=%0b, want 0 0", halted, out_valid);
    end
    tick();
    n_chk++;
    if (out_valid !== 1'b1 || out_pc !== 10'd10 || out_instr !== 32'd110) begin
      n_fail++;
      $display("FAIL halt_redir_target: got valid=%0b pc=%0d instr=%0d, want 1 10 110", out_valid, out_pc, out_instr);
    end
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (out_valid !== 1'b0 || halted !== 1'b0 || fetch_count !== 16'd0) begin
      n_fail++;
      $display("FAIL async_reset: got valid=%0b halted=%0b cnt=%0d, want 0 0 0", out_valid, halted, fetch_count);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    seen.delete();
    redirect_valid = 1'b1; redirect_pc = 10'd50;
    repeat (2) tick();
    redirect_valid = 1'b0;
    n_chk++;
    if (out_valid !== 1'b0 || imem_addr !== 10'd0 || fetch_count !== 16'd0) begin
      n_fail++;
      $display("FAIL idle_ignores_redirect: got valid=%0b addr=%0d cnt=%0d, want 0 0 0", out_valid, imem_addr, fetch_count);
    end
  endtask

  task automatic test_start_ignored();
    bit ok;
    do_reset();
    halt_addr = 6; out_ready = 1'b1; start = 1'b1; start_pc = '0;
    tick();
    start = 1'b0;
    repeat (2) tick();
    start = 1'b1; start_pc = 10'd40;
    repeat (2) tick();
    start = 1'b0;
    repeat (8) tick();
    n_chk++;
    ok = (seen.size() == 7) && (imem_addr === 10'd7);
    foreach (seen[i]) if (seen[i] != i) ok = 1'b0;
    if (!ok) begin n_fail++; $display("FAIL start_ignored: got %0d words addr=%0d, want 0..6 addr 7", seen.size(), imem_addr); end
  endtask

  task automatic test_random();
    logic [AW+DW+AW+AW+1+16:0] got, exp;
    do_reset();
    halt_addr = int'($urandom_range(0, 1023));
    for (int c = 0; c < 400; c++) begin
      got = {out_valid, out_pc, out_instr, imem_addr, halted, fetch_count};
      exp = {mq.size() > 0, m_hpc, m_hin, m_pc, m_state == 2, 16'(m_cnt)};
      n_chk++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL random_c%0d: got v=%0b pc=%0d in=%h a=%0d h=%0b n=%0d want v=%0b pc=%0d in=%h a=%0d h=%0b n=%0d",
                 c, out_valid, out_pc, out_instr, imem_addr, halted, fetch_count,
                 mq.size() > 0, m_hpc, m_hin, m_pc, m_state == 2, m_cnt);
      end
      out_ready      = ($urandom % 4) != 0;
      start          = (c == 0) || (($urandom % 8) == 0);
      start_pc       = AW'(halt_addr - int'($urandom_range(0, 12)));
      redirect_valid = ($urandom % 12) == 0;
      redirect_pc    = AW'(halt_addr - int'($urandom_range(0, 8)));
      tick();
    end
    start = 1'b0; redirect_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_halt_redirect_reset();
    test_start_ignored();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
